// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
//   Shared definitions for seven-segment digit drivers.
//   Segment vectors are ordered bit6..bit0 = g,f,e,d,c,b,a.
//   Glyph values are logical, where 1 means the segment is lit. Any polarity
//   inversion for common-anode boards is done by the driver that consumes
//   these constants.
// -----------------------------------------------------------------------------
package seven_seg_pkg;

  localparam int SEG_WIDTH = 7;

  typedef logic [SEG_WIDTH-1:0] seg_t;
  typedef logic [3:0]           hex_t;

  //                          gfedcba
  localparam seg_t SEG_0 = 7'b0111111;
  localparam seg_t SEG_1 = 7'b0000110;
  localparam seg_t SEG_2 = 7'b1011011;
  localparam seg_t SEG_3 = 7'b1001111;
  localparam seg_t SEG_4 = 7'b1100110;
  localparam seg_t SEG_5 = 7'b1101101;
  localparam seg_t SEG_6 = 7'b1111101;
  localparam seg_t SEG_7 = 7'b0000111;
  localparam seg_t SEG_8 = 7'b1111111;
  localparam seg_t SEG_9 = 7'b1100111;
  localparam seg_t SEG_A = 7'b1110111;
  localparam seg_t SEG_B = 7'b1111100;  // lower-case b
  localparam seg_t SEG_C = 7'b0111001;
  localparam seg_t SEG_D = 7'b1011110;  // lower-case d
  localparam seg_t SEG_E = 7'b1111001;
  localparam seg_t SEG_F = 7'b1110001;

  localparam seg_t SEG_BLANK = 7'b0000000;

endpackage : seven_seg_pkg

// File: rtl/hex_to_seg_decode.sv
// -----------------------------------------------------------------------------
// hex_to_seg_decode
//   Purely combinational lookup from a 4-bit value to a logical seven-segment
//   glyph (0-9, A, b, C, d, E, F).
//   Ports:
//     i_BINARY   in  4  value to decode, unsigned 0-15
//     o_PATTERN  out 7  logical segment pattern, bit6..bit0 = g..a, 1 = lit
// -----------------------------------------------------------------------------
module hex_to_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0]           i_BINARY,
  output logic [SEG_WIDTH-1:0] o_PATTERN
);

  // NOTE: every path assigns o_PATTERN (default first), so no latch is inferred.
  always_comb begin
    o_PATTERN = SEG_BLANK;
    unique case (i_BINARY)
      4'h0: o_PATTERN = SEG_0;
      4'h1: o_PATTERN = SEG_1;
      4'h2: o_PATTERN = SEG_2;
      4'h3: o_PATTERN = SEG_3;
      4'h4: o_PATTERN = SEG_4;
      4'h5: o_PATTERN = SEG_5;
      4'h6: o_PATTERN = SEG_6;
      4'h7: o_PATTERN = SEG_7;
      4'h8: o_PATTERN = SEG_8;
      4'h9: o_PATTERN = SEG_9;
      4'hA: o_PATTERN = SEG_A;
      4'hB: o_PATTERN = SEG_B;
      4'hC: o_PATTERN = SEG_C;
      4'hD: o_PATTERN = SEG_D;
      4'hE: o_PATTERN = SEG_E;
      4'hF: o_PATTERN = SEG_F;
    endcase
  end

endmodule : hex_to_seg_decode

// File: rtl/binary_to_7seg_display.sv
// -----------------------------------------------------------------------------
// binary_to_7seg_display
//   Registered single-digit hex to seven-segment driver with update enable and
//   blanking. One-cycle latency from i_BINARY to o_SEVEN_SEG.
//   Priority at each rising edge: i_RST > hold (!i_EN) > i_BLANK > decode.
//   Ports:
//     i_CLK        in  1  system clock, rising edge
//     i_RST        in  1  synchronous active-high reset, output to all-off
//     i_EN         in  1  1 = capture new pattern, 0 = hold
//     i_BLANK      in  1  1 = all segments off (only when i_EN = 1)
//     i_BINARY     in  4  value to show, 0-15
//     o_SEVEN_SEG  out 7  segment drive, bit0 = a ... bit6 = g
//   Build option:
//     SEG_ACTIVE_LOW_EN  when defined the output is inverted (0 = lit) for
//                        common-anode boards, and reset and blank drive
//                        1111111. Latency is unchanged.
// -----------------------------------------------------------------------------
module binary_to_7seg_display
  import seven_seg_pkg::*;
(
  input  logic                 i_CLK,
  input  logic                 i_RST,
  input  logic                 i_EN,
  input  logic                 i_BLANK,
  input  logic [3:0]           i_BINARY,
  output logic [SEG_WIDTH-1:0] o_SEVEN_SEG
);

  // The register holds the physical pin level, so the polarity is applied
  // before the flop and the hold path simply recirculates the stored value.
`ifdef SEG_ACTIVE_LOW_EN
  localparam seg_t POL_MASK = '1;
`else
  localparam seg_t POL_MASK = '0;
`endif

  localparam seg_t SEG_OFF = SEG_BLANK ^ POL_MASK;

  seg_t decoded;
  seg_t seg_d;
  seg_t seg_q;

  hex_to_seg_decode u_decode (
    .i_BINARY  (i_BINARY),
    .o_PATTERN (decoded)
  );

  // The reset is not handled here because the flop below applies it directly.
  always_comb begin
    seg_d = seg_q;
    if (i_EN) begin
      if (i_BLANK) seg_d = SEG_OFF;
      else         seg_d = decoded ^ POL_MASK;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_CLK) begin
    if (i_RST) seg_q <= SEG_OFF;
    else       seg_q <= seg_d;
  end

  assign o_SEVEN_SEG = seg_q;

endmodule : binary_to_7seg_display

// File: tb/tb_binary_to_7seg_display.sv
// -----------------------------------------------------------------------------
// tb_binary_to_7seg_display
//   Self-checking bench for binary_to_7seg_display. A glyph table plus the
//   priority rules form the reference model. A negedge process compares the
//   DUT with that model on every cycle after the first reset. Directed
//   scenarios also check hand-written literal values. Define SEG_ACTIVE_LOW_EN
//   to exercise the inverted build.
// -----------------------------------------------------------------------------
module tb_binary_to_7seg_display;

  logic       clk;
  logic       rst;
  logic       en;
  logic       blank;
  logic [3:0] bin;
  logic [6:0] seg;

  int total = 0;
  int bad   = 0;

  binary_to_7seg_display dut (
    .i_CLK       (clk),
    .i_RST       (rst),
    .i_EN        (en),
    .i_BLANK     (blank),
    .i_BINARY    (bin),
    .o_SEVEN_SEG (seg)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;  // 40 ns period

  // Reference glyphs, index = displayed value, gfedcba, 1 = lit.
  localparam logic [6:0] GLYPH [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1100111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  // Converts a logical pattern into the pin level of this build.
  function automatic logic [6:0] pol(input logic [6:0] x);
`ifdef SEG_ACTIVE_LOW_EN
    return ~x;
`else
    return x;
`endif
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the pins must show after each rising edge.
  logic [6:0] exp_seg;
  logic       model_valid = 1'b0;

  always @(posedge clk) begin
    if (rst)     exp_seg <= pol(7'b0000000);
    else if (en) exp_seg <= blank ? pol(7'b0000000) : pol(GLYPH[bin]);
    if (rst) model_valid <= 1'b1;
  end

  // Compares the DUT with the model on every cycle, mid-period.
  always @(negedge clk) begin
    if (model_valid) check("cycle", seg, exp_seg);
  end

  // Drives one cycle of inputs at the falling edge, then returns just after
  // the rising edge that samples them.
  task automatic tick(input logic r, input logic e, input logic b, input logic [3:0] v);
    @(negedge clk);
    rst = r; en = e; blank = b; bin = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; blank = 1'b0; bin = 4'd8;

    // Reset with the value 8 present must give all segments off.
    tick(1'b1, 1'b0, 1'b0, 4'd8);
    check("reset", seg, pol(7'b0000000));

    // Sweep through every value, with literal spot checks on the model.
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, 1'b1, 1'b0, 4'(i));
      if (i == 0)  check("sweep_0",  seg, pol(7'b0111111));
      if (i == 2)  check("sweep_2",  seg, pol(7'b1011011));
      if (i == 11) check("sweep_11", seg, pol(7'b1111100));
      if (i == 15) check("sweep_15", seg, pol(7'b1110001));
    end

    // Hold: show 5, then drop the enable and change the input.
    tick(1'b0, 1'b1, 1'b0, 4'd5);
    check("hold_load5", seg, pol(7'b1101101));
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b0, 4'd1);
      check("hold_keep", seg, pol(7'b1101101));
    end
    tick(1'b0, 1'b0, 1'b1, 4'd9);  // blank is ignored while on hold
    check("hold_ignore_blank", seg, pol(7'b1101101));
    tick(1'b0, 1'b1, 1'b0, 4'd1);
    check("hold_release", seg, pol(7'b0000110));

    // Blank, then release to see the value 8.
    tick(1'b0, 1'b1, 1'b1, 4'd8);
    check("blank_on", seg, pol(7'b0000000));
    tick(1'b0, 1'b1, 1'b0, 4'd8);
    check("blank_off", seg, pol(7'b1111111));

    // Reset has priority over an enabled decode.
    tick(1'b1, 1'b1, 1'b0, 4'd7);
    check("reset_priority", seg, pol(7'b0000000));
    tick(1'b0, 1'b1, 1'b0, 4'd7);
    check("after_reset_7", seg, pol(7'b0000111));

    // Reset while on hold still clears the output.
    tick(1'b0, 1'b0, 1'b0, 4'd3);
    tick(1'b1, 1'b0, 1'b0, 4'd3);
    check("reset_during_hold", seg, pol(7'b0000000));

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 4) == 0),
           4'($urandom_range(0, 15)));
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_binary_to_7seg_display
